// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - request/grant arbiter with bus lock for the shared 128x8 motor register file
module regfile_arbiter #(
    parameter int N_REQ      = 3,
    parameter int STARVE_MAX = 8,
    parameter int LOCK_MAX   = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   we,
    input  logic [7*N_REQ-1:0] addr,
    input  logic [8*N_REQ-1:0] wdata,
    input  logic [N_REQ-1:0]   lock,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rvalid,
    output logic [7:0]         rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [6:0]         mem_addr,
    output logic [7:0]         mem_wdata,
    input  logic [7:0]         mem_rdata,
    output logic               lock_err
);

    localparam int PW = $clog2(N_REQ);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] lock_owner;
    logic          lock_active;
    logic [LW-1:0] lock_cnt;
    logic [SW-1:0] starve [N_REQ];

    logic          starve_hit;
    logic [PW-1:0] starve_sel;
    logic          rr_hit;
    logic [PW-1:0] rr_sel;
    logic          gnt_any;
    logic [PW-1:0] gnt_sel;

    // Port visited at position off of a round-robin scan over ports 1..N_REQ-1 starting at ptr.
    function automatic logic [PW-1:0] rr_port(input logic [PW-1:0] ptr, input int off);
        int p;
        p = ((int'(ptr) - 1 + off) % (N_REQ - 1)) + 1;
        return PW'(p);
    endfunction

    // Scan the low-priority ports from rr_ptr for the first starving and the first requesting one.
    always_comb begin
        starve_hit = 1'b0;
        starve_sel = '0;
        rr_hit     = 1'b0;
        rr_sel     = '0;
        for (int off = 0; off < N_REQ - 1; off++) begin
            if (!starve_hit && req[rr_port(rr_ptr, off)] &&
                (starve[rr_port(rr_ptr, off)] >= SW'(STARVE_MAX))) begin
                starve_hit = 1'b1;
                starve_sel = rr_port(rr_ptr, off);
            end
            if (!rr_hit && req[rr_port(rr_ptr, off)]) begin
                rr_hit = 1'b1;
                rr_sel = rr_port(rr_ptr, off);
            end
        end
    end

    // Pick the single winner: lock owner, then starving port, then port 0, then round-robin.
    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = '0;
        if (lock_active) begin
            if (req[lock_owner]) begin
                gnt_any = 1'b1;
                gnt_sel = lock_owner;
            end
        end else if (starve_hit) begin
            gnt_any = 1'b1;
            gnt_sel = starve_sel;
        end else if (req[0]) begin
            gnt_any = 1'b1;
            gnt_sel = '0;
        end else if (rr_hit) begin
            gnt_any = 1'b1;
            gnt_sel = rr_sel;
        end
        if (!resetn) begin
            gnt_any = 1'b0;
        end
    end

    assign gnt    = gnt_any ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_sel) : '0;
    assign mem_en = gnt_any;
    assign rdata  = mem_rdata;

    // Steer the granted port's access onto the RAM port.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                mem_we    = we[i];
                mem_addr  = addr[7*i +: 7];
                mem_wdata = wdata[8*i +: 8];
            end
        end
    end

    // Read data returns one cycle after a read grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvalid <= '0;
        end else begin
            rvalid <= gnt & ~we;
        end
    end

    // Count consecutive losing cycles of each low-priority requester, saturating.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int j = 0; j < N_REQ; j++) begin
                starve[j] <= '0;
            end
        end else begin
            starve[0] <= '0;
            for (int j = 1; j < N_REQ; j++) begin
                if (req[j] && !gnt[j]) begin
                    if (starve[j] != SW'(STARVE_MAX)) begin
                        starve[j] <= starve[j] + SW'(1);
                    end
                end else begin
                    starve[j] <= '0;
                end
            end
        end
    end

    // Advance the round-robin pointer past a low-priority port won outside a lock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= PW'(1);
        end else if (gnt_any && !lock_active && (gnt_sel != '0)) begin
            rr_ptr <= (gnt_sel == PW'(N_REQ - 1)) ? PW'(1) : gnt_sel + PW'(1);
        end
    end

    // Lock acquisition, release at burst end, and forced release on timeout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
            lock_cnt    <= '0;
            lock_err    <= 1'b0;
        end else if (lock_active) begin
            if (lock_cnt == LW'(LOCK_MAX - 1)) begin
                lock_active <= 1'b0;
                lock_err    <= 1'b1;
            end else if (!lock[lock_owner] && (gnt_any || !req[lock_owner])) begin
                lock_active <= 1'b0;
            end else begin
                lock_cnt <= lock_cnt + LW'(1);
            end
        end else if (gnt_any && lock[gnt_sel]) begin
            lock_active <= 1'b1;
            lock_owner  <= gnt_sel;
            lock_cnt    <= '0;
        end
    end

endmodule
